// File: rtl/i2s_rx_ctrl.sv
// I2S master receive controller: generates BCLK/LRCLK, captures ADCDAT, hands stereo pairs over VALID/READY.
// Define I2S_RX_LEFT_JUSTIFIED_EN for left-justified capture instead of the standard one-bit-delay I2S format.
module i2s_rx_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16,
  parameter int SLOT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              adcdat,
  output logic              bclk,
  output logic              lrclk,
  output logic [WORD_W-1:0] left_data,
  output logic [WORD_W-1:0] right_data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  localparam logic [BIT_W-1:0] CAP_LAST = BIT_W'(WORD_W - 1);
`else
  localparam logic [BIT_W-1:0] CAP_LAST = BIT_W'(WORD_W);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shadow_l;
  logic [WORD_W-1:0] shadow_r;
  logic              pair_done;

  logic active;
  logic tick;
  logic rise;
  logic fall;
  logic frame_end;
  logic in_window;
  logic capture;

  always_comb begin
    active    = (state != IDLE);
    tick      = active && (div == DIV_LAST);
    rise      = tick && !bclk;
    fall      = tick && bclk;
    frame_end = fall && lrclk && (bit_cnt == BIT_LAST);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    in_window = (bit_cnt <= CAP_LAST);
`else
    in_window = (bit_cnt != '0) && (bit_cnt <= CAP_LAST);
`endif
    capture   = rise && in_window;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A run request during DRAIN takes priority over stopping at the frame end.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN: begin
        if (en) begin
          state_next = RUN;
        end else if (frame_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div       <= '0;
      bit_cnt   <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      shadow_l  <= '0;
      shadow_r  <= '0;
      pair_done <= 1'b0;
    end else begin
      pair_done <= capture && lrclk && (bit_cnt == CAP_LAST);
      if (!active) begin
        div      <= '0;
        bit_cnt  <= '0;
        bclk     <= 1'b0;
        lrclk    <= 1'b0;
        shadow_l <= '0;
        shadow_r <= '0;
      end else begin
        div <= tick ? '0 : div + DIV_W'(1);
        if (tick) begin
          bclk <= !bclk;
        end
        // LRCLK only moves on the BCLK fall that ends a slot.
        if (fall) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            lrclk   <= !lrclk;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        if (state_next == IDLE) begin
          shadow_l <= '0;
          shadow_r <= '0;
        end else if (capture) begin
          if (lrclk) begin
            shadow_r <= {shadow_r[WORD_W-2:0], adcdat};
          end else begin
            shadow_l <= {shadow_l[WORD_W-2:0], adcdat};
          end
        end
      end
    end
  end

  // A new pair always replaces the held one; overrun set takes priority over clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else if (pair_done) begin
      left_data  <= shadow_l;
      right_data <= shadow_r;
      valid      <= 1'b1;
      if (valid && !ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end else begin
      if (valid && ready) begin
        valid <= 1'b0;
      end
      if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
